// File: rtl/ro_result_packer.sv
// Drains ring-oscillator samples from a show-ahead FIFO and packs them into cache lines.
// Completed lines go to the DMA write channel, and done is raised after a programmed number of lines.
module ro_result_packer #(
  parameter int CL_DATA_WIDTH = 512,
  parameter int RESULT_WIDTH  = 32,
  parameter int FIFO_WIDTH    = 20,
  parameter int SIZE_WIDTH    = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic [SIZE_WIDTH-1:0]    num_lines,
  input  logic                     fifo_empty,
  input  logic [FIFO_WIDTH-1:0]    fifo_rd_data,
  output logic                     fifo_rd_en,
  input  logic                     wr_full,
  output logic                     wr_en,
  output logic [CL_DATA_WIDTH-1:0] wr_data,
  output logic [SIZE_WIDTH-1:0]    lines_written,
  output logic                     done
);

  localparam int RESULTS_PER_CL = CL_DATA_WIDTH / RESULT_WIDTH;
  localparam int CNT_W          = $clog2(RESULTS_PER_CL + 1);
  localparam int POP_W          = SIZE_WIDTH + $clog2(RESULTS_PER_CL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CL_DATA_WIDTH-1:0] buffer_q, buffer_d;
  logic [SIZE_WIDTH-1:0]    target_q, target_d;
  logic [SIZE_WIDTH-1:0]    lines_q, lines_d;
  logic [POP_W-1:0]         popped_q, popped_d;

  logic [POP_W-1:0]         pop_limit;
  logic                     pop_limit_reached;
  logic                     line_full;
  logic                     go_accept;
  logic                     last_write;

  // Total samples the current job needs; popping stops here so surplus stays in the FIFO.
  assign pop_limit         = POP_W'(target_q) * POP_W'(RESULTS_PER_CL);
  assign pop_limit_reached = (popped_q >= pop_limit);
  assign line_full         = (count_q == CNT_W'(RESULTS_PER_CL));
  assign go_accept         = go && (state_q != ST_RUN);
  assign last_write        = wr_en && ((lines_q + SIZE_WIDTH'(1)) == target_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      buffer_q <= '0;
      target_q <= '0;
      lines_q  <= '0;
      popped_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      buffer_q <= buffer_d;
      target_q <= target_d;
      lines_q  <= lines_d;
      popped_q <= popped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) state_d = (num_lines == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last_write) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop is allowed into a full line only when that line leaves in the same cycle.
  always_comb begin
    wr_en      = 1'b0;
    fifo_rd_en = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        wr_en      = line_full && !wr_full;
        fifo_rd_en = !fifo_empty && !pop_limit_reached &&
                     ((count_q < CNT_W'(RESULTS_PER_CL)) || wr_en);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    buffer_d = buffer_q;
    target_d = target_q;
    lines_d  = lines_q;
    popped_d = popped_q;
    if (go_accept) begin
      target_d = num_lines;
      count_d  = '0;
      lines_d  = '0;
      popped_d = '0;
    end else if (state_q == ST_RUN) begin
      // New samples enter at the top, so the first sample of a line ends up in slot 0.
      if (fifo_rd_en) begin
        buffer_d = {RESULT_WIDTH'(fifo_rd_data), buffer_q[CL_DATA_WIDTH-1:RESULT_WIDTH]};
        popped_d = popped_q + POP_W'(1);
      end
      if (wr_en && fifo_rd_en)      count_d = CNT_W'(1);
      else if (wr_en)               count_d = '0;
      else if (fifo_rd_en)          count_d = count_q + CNT_W'(1);
      if (wr_en && (lines_q < target_q)) lines_d = lines_q + SIZE_WIDTH'(1);
    end
  end

  assign wr_data       = buffer_q;
  assign lines_written = lines_q;

endmodule

// File: tb/tb_ro_result_packer.sv
// Scoreboard bench for ro_result_packer: the FIFO model feeds samples, and each expected line
// is queued as it is issued and checked by a monitor on every DMA write.
module tb_ro_result_packer;

  logic         clk;
  logic         rst;
  logic         go;
  logic [64:0]  num_lines;
  logic         fifo_empty;
  logic [19:0]  fifo_rd_data;
  logic         fifo_rd_en;
  logic         wr_full;
  logic         wr_en;
  logic [511:0] wr_data;
  logic [64:0]  lines_written;
  logic         done;

  ro_result_packer dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .num_lines     (num_lines),
    .fifo_empty    (fifo_empty),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .wr_full       (wr_full),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .lines_written (lines_written),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0]  src[$];
  logic [511:0] exp_q[$];
  int           wr_cycs[$];
  int           rd_cycs[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           rd_total = 0;
  int           wr_total = 0;
  int           done_cyc = -1;
  logic         done_prev = 1'b0;
  logic         rd_seen = 1'b0;
  logic         gap_en = 1'b0;
  logic         gap_phase = 1'b0;
  logic [511:0] last_wr = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Show-ahead FIFO model: pop what the DUT requested in the previous cycle.
  always begin
    logic [19:0] tmp;
    @(posedge clk);
    #2;
    if (rd_seen && src.size() > 0) tmp = src.pop_front();
    gap_phase    = gap_en ? ~gap_phase : 1'b0;
    fifo_empty   = (src.size() == 0) || gap_phase;
    fifo_rd_data = (src.size() > 0) ? src[0] : 20'h0;
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    rd_seen = fifo_rd_en;
    if (fifo_rd_en) begin
      rd_total++;
      rd_cycs.push_back(cyc);
    end
    if (wr_en) begin
      wr_total++;
      wr_cycs.push_back(cyc);
      last_wr = wr_data;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got %0h expected no write", wr_data);
      end else begin
        chk("line_data", wr_data, exp_q.pop_front());
      end
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nsample();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [64:0] n);
    step();
    go        = 1'b1;
    num_lines = n;
    step();
    go        = 1'b0;
  endtask

  task automatic push_line(input logic [19:0] base);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) begin
      src.push_back(base + 20'(i));
      l[i*32 +: 32] = {12'h000, base + 20'(i)};
    end
    exp_q.push_back(l);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin
      nsample();
      k++;
    end while (!done && k < budget);
    chk("done_reached", 512'(done), 512'(1));
  endtask

  initial begin
    logic [511:0] mask;
    logic [511:0] held;
    int           rd_base;
    int           wr_base;
    int           k;

    rst = 1'b1; go = 1'b0; num_lines = '0; wr_full = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
    repeat (3) nsample();
    chk("rst_wr_en", 512'(wr_en), 512'(0));
    chk("rst_rd_en", 512'(fifo_rd_en), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_lines", 512'(lines_written), 512'(0));
    chk("rst_wr_data", wr_data, 512'(0));
    step();
    rst = 1'b0;

    // Basic packing: samples 1..16 into one line
    wr_cycs.delete(); rd_cycs.delete();
    push_line(20'h00001);
    start(65'd1);
    wait_done(100);
    chk("basic_lines", 512'(lines_written), 512'(1));
    chk("basic_writes", 512'(wr_cycs.size()), 512'(1));
    chk("basic_pops", 512'(rd_cycs.size()), 512'(16));
    chk("basic_slot0", 512'(last_wr[31:0]), 512'(32'h1));
    chk("basic_slot15", 512'(last_wr[511:480]), 512'(32'h10));
    mask = '0;
    for (int i = 0; i < 16; i++) mask[i*32+20 +: 12] = 12'hFFF;
    chk("basic_upper_zero", last_wr & mask, 512'(0));
    if (wr_cycs.size() == 1 && rd_cycs.size() == 16) begin
      chk("basic_wr_latency", 512'(wr_cycs[0]), 512'(rd_cycs[15] + 1));
      chk("basic_done_latency", 512'(done_cyc), 512'(wr_cycs[0] + 1));
    end

    // Zero-length go from DONE: clears lines_written, stays done, no traffic
    src.push_back(20'h00777);
    rd_base = rd_total; wr_base = wr_total;
    start(65'd0);
    nsample();
    chk("zero_done", 512'(done), 512'(1));
    chk("zero_lines_cleared", 512'(lines_written), 512'(0));
    repeat (5) nsample();
    chk("zero_no_pops", 512'(rd_total - rd_base), 512'(0));
    chk("zero_no_writes", 512'(wr_total - wr_base), 512'(0));
    chk("zero_fifo_untouched", 512'(src.size()), 512'(1));
    step();
    src.delete();

    // Streaming: 4 lines back to back, a 65th sample must stay in the FIFO
    for (int j = 0; j < 4; j++) push_line(20'h00100 + 20'(j * 16));
    src.push_back(20'h7FFFF);
    wr_cycs.delete(); rd_cycs.delete();
    start(65'd4);
    nsample();
    chk("go_clears_done", 512'(done), 512'(0));
    chk("go_clears_lines", 512'(lines_written), 512'(0));
    repeat (20) step();
    go = 1'b1; num_lines = 65'd1;
    step();
    go = 1'b0;
    wait_done(200);
    chk("stream_lines", 512'(lines_written), 512'(4));
    chk("stream_pops", 512'(rd_cycs.size()), 512'(64));
    chk("stream_leftover", 512'(src.size()), 512'(1));
    chk("stream_writes", 512'(wr_cycs.size()), 512'(4));
    if (rd_cycs.size() == 64 && wr_cycs.size() == 4) begin
      chk("stream_contiguous", 512'(rd_cycs[63] - rd_cycs[0]), 512'(63));
      for (int j = 0; j < 3; j++)
        chk("stream_spacing", 512'(wr_cycs[j+1] - wr_cycs[j]), 512'(16));
      chk("stream_done_latency", 512'(done_cyc), 512'(wr_cycs[3] + 1));
    end
    step();
    src.delete();

    // Backpressure: a full line held while wr_full is high
    wr_full = 1'b1;
    push_line(20'h00200);
    push_line(20'h00210);
    held = exp_q[0];
    rd_base = rd_total;
    start(65'd2);
    k = 0;
    do begin
      nsample();
      k++;
    end while (rd_total - rd_base < 16 && k < 100);
    chk("bp_first_line_popped", 512'(rd_total - rd_base), 512'(16));
    for (int i = 0; i < 10; i++) begin
      nsample();
      chk("bp_wr_en_low", 512'(wr_en), 512'(0));
      chk("bp_rd_en_low", 512'(fifo_rd_en), 512'(0));
      chk("bp_data_stable", wr_data, held);
    end
    step();
    wr_full = 1'b0;
    nsample();
    chk("bp_release_wr_en", 512'(wr_en), 512'(1));
    chk("bp_release_data", wr_data, held);
    wait_done(100);
    chk("bp_lines", 512'(lines_written), 512'(2));
    chk("bp_pops", 512'(rd_total - rd_base), 512'(32));

    // FIFO empty every other cycle
    gap_en = 1'b1;
    push_line(20'h00300);
    push_line(20'h00310);
    rd_base = rd_total;
    start(65'd2);
    wait_done(300);
    gap_en = 1'b0;
    chk("gap_lines", 512'(lines_written), 512'(2));
    chk("gap_pops", 512'(rd_total - rd_base), 512'(32));
    chk("gap_fifo_drained", 512'(src.size()), 512'(0));

    // Reset after 7 pops of a line: nothing written, next line holds only new samples
    for (int i = 0; i < 16; i++) src.push_back(20'h000A0 + 20'(i));
    rd_base = rd_total; wr_base = wr_total;
    start(65'd1);
    k = 0;
    do begin
      nsample();
      k++;
    end while (rd_total - rd_base < 7 && k < 100);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 512'(wr_en), 512'(0));
    chk("mid_rst_rd_en", 512'(fifo_rd_en), 512'(0));
    chk("mid_rst_done", 512'(done), 512'(0));
    chk("mid_rst_lines", 512'(lines_written), 512'(0));
    chk("mid_rst_wr_data", wr_data, 512'(0));
    chk("mid_rst_pops", 512'(rd_total - rd_base), 512'(7));
    step();
    rst = 1'b0;
    src.delete();
    chk("mid_rst_no_write", 512'(wr_total - wr_base), 512'(0));
    push_line(20'h00400);
    start(65'd1);
    wait_done(100);
    chk("post_rst_lines", 512'(lines_written), 512'(1));

    repeat (3) step();
    chk("scoreboard_empty", 512'(exp_q.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ro_result_packer.md
Name: ro_result_packer

Overview:
- Downstream consumer of the ring-oscillator sample FIFO in ro_top.
- Drains FIFO_WIDTH-bit samples and zero-extends each to RESULT_WIDTH.
- Packs RESULTS_PER_CL results into one cache line and drives the DMA write channel with backpressure.
- Counts lines written and asserts done after a software-programmed number of lines. Replaces the ad-hoc packing logic inside the AFU top level.

Parameters:
- CL_DATA_WIDTH, 512, cache-line width in bits.
- RESULT_WIDTH, 32, width of each packed result slot; must divide CL_DATA_WIDTH.
- FIFO_WIDTH, 20, width of each FIFO sample; must be <= RESULT_WIDTH.
- SIZE_WIDTH, 65, width of the line-count inputs and outputs.
- Derived, not overridable: RESULTS_PER_CL = CL_DATA_WIDTH/RESULT_WIDTH (16).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- go  in  1  single-cycle start pulse; accepted only in IDLE or DONE.
- num_lines  in  SIZE_WIDTH  number of cache lines to write; sampled when go is accepted.
- fifo_empty  in  1  sample FIFO empty.
- fifo_rd_data  in  FIFO_WIDTH  show-ahead FIFO head; valid whenever !fifo_empty.
- fifo_rd_en  out  1  pop FIFO head this cycle.
- wr_full  in  1  DMA write channel full.
- wr_en  out  1  write wr_data to DMA this cycle.
- wr_data  out  CL_DATA_WIDTH  packed cache line.
- lines_written  out  SIZE_WIDTH  lines accepted by DMA since the last accepted go.
- done  out  1  all num_lines written; held until the next accepted go.

Behaviour:
- Reset values:
  - state = IDLE; fifo_rd_en = 0; wr_en = 0; done = 0; lines_written = 0.
  - Internal count_r = 0; buffer_r = 0; target_r = 0.
  - wr_data reflects buffer_r, so it is 0 at reset.
- State machine: IDLE, RUN, DONE.
  - IDLE --go--> RUN. On this transition: target_r <= num_lines, count_r <= 0, lines_written <= 0, done <= 0.
  - If num_lines == 0, go moves directly to DONE and done = 1 on the next cycle.
  - RUN --(wr_en && lines_written+1 == target_r)--> DONE.
  - DONE --go--> RUN, with the same initialisation as from IDLE.
  - go in RUN is ignored.
- Packing (RUN only):
  - fifo_rd_en = RUN && !fifo_empty && !lines_remaining_reached && (count_r < RESULTS_PER_CL || wr_en).
  - On a pop: buffer_r <= {zero-extended fifo_rd_data, buffer_r[CL_DATA_WIDTH-1:RESULT_WIDTH]}.
  - Result: the first sample of a line lands in bits [RESULT_WIDTH-1:0] and the 16th in the top slot. Upper RESULT_WIDTH-FIFO_WIDTH bits of each slot are 0.
  - No pop is issued once popped_total reaches target_r*RESULTS_PER_CL; surplus FIFO data is left in the FIFO.
- Write handshake:
  - wr_en = RUN && count_r == RESULTS_PER_CL && !wr_full. Combinational, same cycle the buffer becomes full if the DMA is not full.
  - wr_data = buffer_r; a write is accepted on any cycle with wr_en = 1.
  - wr_full high holds the line: wr_en = 0, buffer and count are frozen, and fifo_rd_en = 0.
- Simultaneous write and pop: same edge gives count_r <= 1, and the popped sample enters the top slot. The old line is fully shifted out after 15 more pops, so there is no gap between lines.
- count_r update: write only -> 0; pop only -> count_r+1; both -> 1.
- lines_written increments on each accepted write, saturating at target_r.
- Sustained throughput: 1 sample per cycle, with no bubble at line boundaries when wr_full = 0.
- Reset mid-operation: all state is cleared immediately (asynchronous). A partial line is discarded and no write is issued.
- No partial-line flush: software guarantees the sample total is target_r*RESULTS_PER_CL.

Test Plan:
- Basic packing: go with num_lines = 1; push 16 samples 0x00001..0x00010 back-to-back. Expect exactly one wr_en pulse on the cycle after the 16th pop. wr_data[31:0] = 0x1, wr_data[511:480] = 0x10, upper 12 bits of each slot = 0. lines_written = 1; done = 1 the next cycle.
- Streaming: num_lines = 4 with 64 samples continuously available and wr_full = 0. Expect fifo_rd_en high for 64 consecutive cycles and 4 wr_en pulses spaced exactly 16 cycles apart. done is asserted one cycle after the 4th write. The 65th FIFO entry is not popped.
- Backpressure: full line pending, hold wr_full = 1 for 10 cycles. Expect wr_en = 0, fifo_rd_en = 0 and wr_data stable for those 10 cycles. wr_en is asserted in the cycle wr_full drops, with data unchanged.
- Empty FIFO gaps: alternate fifo_empty 1/0 every cycle for 32 samples with num_lines = 2. Expect 2 correct lines, with samples in order and no duplicates or drops.
- Zero length / go handling: go with num_lines = 0 -> done = 1 next cycle, no pops, no writes. A go pulse in RUN is ignored (lines_written unaffected). A go in DONE clears done and lines_written.
- Reset mid-line: after 7 pops assert rst for 1 cycle. Expect all outputs 0 immediately and state IDLE. A subsequent go with 16 samples produces a line containing only the new samples.
